// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the IF requester, DM requester and memory-side signals of mem_port_arbiter.
// Latency: none; wires only.
// Backpressure: requesters hold *_req until their *_ready pulse; the arbiter never accepts early.
//
// Ports (signals):
//   IF  : if_req, if_addr -> arbiter; if_rdata, if_ready <- arbiter
//   DM  : dm_req, dm_we, dm_addr, dm_wdata -> arbiter; dm_rdata, dm_ready <- arbiter
//   MEM : mem_we, mem_addr, mem_wdata <- arbiter; mem_rdata -> arbiter
//   busy: arbiter is in an access (BUSY or RESP)
// Modports: master = requesters + memory (the environment), slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  mem_we, mem_addr, mem_wdata,
        input  busy
    );

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output mem_we, mem_addr, mem_wdata,
        output busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port word memory between the IF and DM ports, DM priority, IF starvation bounded.
// Latency: grant edge -> ready pulse after MEM_LATENCY+1 edges; each access occupies MEM_LATENCY+2 cycles.
// Backpressure: requests are level and held until ready; requests arriving in BUSY/RESP wait for IDLE.
//
// Ports:
//   ref_clk : rising-edge clock
//   rst     : synchronous active-high reset; abandons any access in flight without a ready pulse
//   bus     : mem_port_arbiter_if.slave (IF/DM request side and memory side, see interface)
// Parameters: MEM_LATENCY (1..8), STARVE_LIMIT (max DM grants in a row while IF waits), ADDR_W.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              ref_clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    state_t              state,    stateNxt;
    owner_t              owner,    ownerNxt;
    logic [CNT_W-1:0]    latCnt,   latCntNxt;
    logic [STREAK_W-1:0] dmStreak, dmStreakNxt;
    logic                memWe,    memWeNxt;
    logic [ADDR_W-1:0]   memAddr,  memAddrNxt;
    logic [31:0]         memWdata, memWdataNxt;
    logic [31:0]         ifRdata,  ifRdataNxt;
    logic [31:0]         dmRdata,  dmRdataNxt;
    logic                ifReady,  ifReadyNxt;
    logic                dmReady,  dmReadyNxt;
    logic                busyReg,  busyNxt;
    logic                grantIf;

    // Next-state and next-output logic. Every output is a register, so this
    // block only computes the values loaded at the coming edge.
    always_comb begin
        stateNxt    = state;
        ownerNxt    = owner;
        latCntNxt   = latCnt;
        dmStreakNxt = dmStreak;
        memWeNxt    = 1'b0;          // write strobe lasts only the first BUSY cycle
        memAddrNxt  = memAddr;
        memWdataNxt = memWdata;
        ifRdataNxt  = ifRdata;
        dmRdataNxt  = dmRdata;
        ifReadyNxt  = 1'b0;          // ready is a single-cycle pulse
        dmReadyNxt  = 1'b0;
        busyNxt     = busyReg;
        grantIf     = 1'b0;

        case (state)
            IDLE: begin
                // IF wins only when DM is idle or DM has used up its streak
                // while IF was waiting.
                grantIf = bus.if_req && (!bus.dm_req || (dmStreak == STREAK_MAX));
                if (bus.if_req || bus.dm_req) begin
                    stateNxt  = BUSY;
                    busyNxt   = 1'b1;
                    latCntNxt = LAT_LOAD;
                    if (grantIf) begin
                        ownerNxt    = OWN_IF;
                        memAddrNxt  = bus.if_addr;
                        memWdataNxt = '0;
                        memWeNxt    = 1'b0;
                        dmStreakNxt = '0;
                    end else begin
                        ownerNxt    = OWN_DM;
                        memAddrNxt  = bus.dm_addr;
                        memWdataNxt = bus.dm_wdata;
                        memWeNxt    = bus.dm_we;
                        if (bus.if_req) begin
                            if (dmStreak != STREAK_MAX) begin
                                dmStreakNxt = dmStreak + 1'b1;
                            end
                        end else begin
                            dmStreakNxt = '0;
                        end
                    end
                end
            end

            BUSY: begin
                if (latCnt != '0) begin
                    latCntNxt = latCnt - 1'b1;
                end else begin
                    // Stores capture too; the value is meaningless but harmless.
                    stateNxt = RESP;
                    if (owner == OWN_IF) begin
                        ifRdataNxt = bus.mem_rdata;
                        ifReadyNxt = 1'b1;
                    end else begin
                        dmRdataNxt = bus.mem_rdata;
                        dmReadyNxt = 1'b1;
                    end
                end
            end

            RESP: begin
                // Requests are ignored here; the requester drops req this cycle.
                stateNxt = IDLE;
                busyNxt  = 1'b0;
            end

            default: begin
                stateNxt = IDLE;
                busyNxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            latCnt   <= '0;
            dmStreak <= '0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifRdata  <= '0;
            dmRdata  <= '0;
            ifReady  <= 1'b0;
            dmReady  <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            state    <= stateNxt;
            owner    <= ownerNxt;
            latCnt   <= latCntNxt;
            dmStreak <= dmStreakNxt;
            memWe    <= memWeNxt;
            memAddr  <= memAddrNxt;
            memWdata <= memWdataNxt;
            ifRdata  <= ifRdataNxt;
            dmRdata  <= dmRdataNxt;
            ifReady  <= ifReadyNxt;
            dmReady  <= dmReadyNxt;
            busyReg  <= busyNxt;
        end
    end

    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.if_rdata  = ifRdata;
    assign bus.if_ready  = ifReady;
    assign bus.dm_rdata  = dmRdata;
    assign bus.dm_ready  = dmReady;
    assign bus.busy      = busyReg;

endmodule
